// File: rtl/pcm_pkg.sv
// Shared definitions for the PCM memory arbiter: FSM state encoding,
// bus widths and the number of requesting CPUs.
package pcm_pkg;

    localparam int unsigned PCM_ADDR_W = 20;
    localparam int unsigned PCM_DATA_W = 16;
    localparam int unsigned NUM_CPU    = 4;
    localparam int unsigned CPU_IDX_W  = 2;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } pcm_state_t;

endpackage

// File: rtl/pcm_rr_pick.sv
// Round-robin requester pick: scans req starting at ptr (wrapping) and
// returns the first requester as both a one-hot vector and an index.
// Ports:
//   req    - request vector, bit i is CPU i
//   ptr    - index of the highest-priority requester this round
//   onehot - one-hot winner, zero when no request
//   index  - winner index, zero when no request
module pcm_rr_pick
    import pcm_pkg::*;
(
    input  logic [NUM_CPU-1:0]   req,
    input  logic [CPU_IDX_W-1:0] ptr,
    output logic [NUM_CPU-1:0]   onehot,
    output logic [CPU_IDX_W-1:0] index
);

    logic                 found;
    logic [CPU_IDX_W-1:0] cand;

    // First requester at or after ptr, modulo the CPU count.
    always_comb begin
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < NUM_CPU; k++) begin
            cand = ptr + CPU_IDX_W'(k);
            if (!found && req[cand]) begin
                found         = 1'b1;
                index         = cand;
                onehot[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcm_mem_arbiter.sv
// Four-CPU arbiter for a single-port PCM memory. One access at a time:
// IDLE -> ISSUE -> (WAIT for reads) -> DONE -> IDLE, with a one-cycle
// cpu_ready pulse to the winner in DONE.
// Build option: define PCM_ARB_CPU0_PRIO_EN to give CPU0 absolute priority
// (round-robin then covers CPUs 1-3 only); default is plain 4-way rotation.
// Ports:
//   clk, reset (async active-low, release synchronized), init (sync clear)
//   cpu_req/cpu_write/cpu_addr/cpu_data_in - per-CPU request payload
//   cpu_ready/cpu_data_out                 - per-CPU completion and read data
//   grant/busy                             - current owner / not idle
//   pcm_mem_mm_*                           - memory-side bus
module pcm_mem_arbiter
    import pcm_pkg::*;
#(
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned NUM_CPU  = pcm_pkg::NUM_CPU
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  init,
    input  logic [NUM_CPU-1:0]                    cpu_req,
    input  logic [NUM_CPU-1:0]                    cpu_write,
    input  logic [NUM_CPU-1:0][PCM_ADDR_W-1:0]    cpu_addr,
    input  logic [NUM_CPU-1:0][PCM_DATA_W-1:0]    cpu_data_in,
    output logic [NUM_CPU-1:0]                    cpu_ready,
    output logic [NUM_CPU-1:0][PCM_DATA_W-1:0]    cpu_data_out,
    output logic [NUM_CPU-1:0]                    grant,
    output logic                                  busy,
    output logic [PCM_ADDR_W-1:0]                 pcm_mem_mm_address,
    output logic                                  pcm_mem_mm_chipselect,
    output logic                                  pcm_mem_mm_clken,
    output logic                                  pcm_mem_mm_write,
    output logic [PCM_DATA_W-1:0]                 pcm_mem_mm_writedata,
    output logic [1:0]                            pcm_mem_mm_byteenable,
    input  logic [PCM_DATA_W-1:0]                 pcm_mem_mm_readdata
);

    pcm_state_t           state;
    logic [CPU_IDX_W-1:0] rr_ptr;
    logic [CPU_IDX_W-1:0] win_idx;
    logic                 win_wr;
    logic [CNT_W-1:0]     cnt;
    logic                 rst_meta;
    logic                 rst_sync_n;

    logic [NUM_CPU-1:0]   rr_req;
    logic [NUM_CPU-1:0]   rr_onehot;
    logic [CPU_IDX_W-1:0] rr_idx;
    logic [NUM_CPU-1:0]   pick_onehot;
    logic [CPU_IDX_W-1:0] pick_idx;

    // Reset asserts immediately, releases on the second clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

`ifdef PCM_ARB_CPU0_PRIO_EN
    // CPU0 bypasses the rotation; CPUs 1-3 rotate among themselves.
    assign rr_req      = {cpu_req[NUM_CPU-1:1], 1'b0};
    assign pick_idx    = cpu_req[0] ? 2'd0    : rr_idx;
    assign pick_onehot = cpu_req[0] ? 4'b0001 : rr_onehot;
`else
    assign rr_req      = cpu_req;
    assign pick_idx    = rr_idx;
    assign pick_onehot = rr_onehot;
`endif

    pcm_rr_pick u_rr_pick (
        .req    (rr_req),
        .ptr    (rr_ptr),
        .onehot (rr_onehot),
        .index  (rr_idx)
    );

    // Access FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state                 <= IDLE;
            rr_ptr                <= '0;
            win_idx               <= '0;
            win_wr                <= 1'b0;
            cnt                   <= '0;
            grant                 <= '0;
            busy                  <= 1'b0;
            cpu_ready             <= '0;
            cpu_data_out          <= '0;
            pcm_mem_mm_address    <= '0;
            pcm_mem_mm_chipselect <= 1'b0;
            pcm_mem_mm_clken      <= 1'b0;
            pcm_mem_mm_write      <= 1'b0;
            pcm_mem_mm_writedata  <= '0;
            pcm_mem_mm_byteenable <= 2'b00;
        end else if (init) begin
            // Abandon whatever is in flight; read data registers are kept.
            state                 <= IDLE;
            rr_ptr                <= '0;
            cnt                   <= '0;
            grant                 <= '0;
            busy                  <= 1'b0;
            cpu_ready             <= '0;
            pcm_mem_mm_address    <= '0;
            pcm_mem_mm_chipselect <= 1'b0;
            pcm_mem_mm_clken      <= 1'b0;
            pcm_mem_mm_write      <= 1'b0;
            pcm_mem_mm_writedata  <= '0;
            pcm_mem_mm_byteenable <= 2'b00;
        end else begin
            cpu_ready <= '0;
            unique case (state)
                IDLE: begin
                    if (|cpu_req) begin
                        win_idx               <= pick_idx;
                        win_wr                <= cpu_write[pick_idx];
                        grant                 <= pick_onehot;
                        busy                  <= 1'b1;
                        pcm_mem_mm_address    <= cpu_addr[pick_idx];
                        pcm_mem_mm_writedata  <= cpu_data_in[pick_idx];
                        pcm_mem_mm_write      <= cpu_write[pick_idx];
                        pcm_mem_mm_chipselect <= 1'b1;
                        pcm_mem_mm_clken      <= 1'b1;
                        pcm_mem_mm_byteenable <= 2'b11;
                        state                 <= ISSUE;
                    end
                end
                ISSUE: begin
                    pcm_mem_mm_address    <= '0;
                    pcm_mem_mm_writedata  <= '0;
                    pcm_mem_mm_write      <= 1'b0;
                    pcm_mem_mm_chipselect <= 1'b0;
                    pcm_mem_mm_clken      <= 1'b0;
                    pcm_mem_mm_byteenable <= 2'b00;
                    cnt                   <= '0;
                    if (win_wr) begin
                        cpu_ready <= grant;
                        state     <= DONE;
                    end else begin
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // Read data is valid on the last of READ_LAT wait cycles.
                    if (cnt == CNT_W'(READ_LAT - 1)) begin
                        cpu_data_out[win_idx] <= pcm_mem_mm_readdata;
                        cpu_ready             <= grant;
                        state                 <= DONE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                DONE: begin
                    rr_ptr <= win_idx + 2'd1;
                    grant  <= '0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_mem_arbiter.sv
// Bench for pcm_mem_arbiter: directed single-access vectors, init and
// reset corner cases, full contention, and a randomized run against a
// transaction-timeline model of the arbiter.
module tb_pcm_mem_arbiter;

    localparam int RL = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              init;
    logic [3:0]        a_req;
    logic [3:0]        a_wr;
    logic [3:0][19:0]  a_addr;
    logic [3:0][15:0]  a_data;
    logic [3:0]        cpu_ready;
    logic [3:0][15:0]  dout;
    logic [3:0]        grant;
    logic              busy;
    logic [19:0]       mm_address;
    logic              mm_cs;
    logic              mm_clken;
    logic              mm_write;
    logic [15:0]       mm_wdata;
    logic [1:0]        mm_be;
    logic [15:0]       readdata;

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [3:0][15:0]  m_dout;
    int                order[$];

    typedef struct {
        logic [1:0]  cpu;
        logic        wr;
        logic [19:0] addr;
        logic [15:0] data;
        int          lat;
        logic [15:0] rd;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    pcm_mem_arbiter #(.READ_LAT(RL), .NUM_CPU(4)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .init                  (init),
        .cpu_req               (a_req),
        .cpu_write             (a_wr),
        .cpu_addr              (a_addr),
        .cpu_data_in           (a_data),
        .cpu_ready             (cpu_ready),
        .cpu_data_out          (dout),
        .grant                 (grant),
        .busy                  (busy),
        .pcm_mem_mm_address    (mm_address),
        .pcm_mem_mm_chipselect (mm_cs),
        .pcm_mem_mm_clken      (mm_clken),
        .pcm_mem_mm_write      (mm_write),
        .pcm_mem_mm_writedata  (mm_wdata),
        .pcm_mem_mm_byteenable (mm_be),
        .pcm_mem_mm_readdata   (readdata)
    );

    // Memory contents as a fixed function of address.
    function automatic logic [15:0] mem_f(input logic [19:0] a);
        return 16'(a[15:0] + (a[15:0] >> 1));
    endfunction

    // Memory returns data exactly RL cycles after the issue cycle, junk otherwise.
    logic [RL-1:0]       pv;
    logic [RL-1:0][15:0] pd;
    always @(posedge clk) begin
        pv[0] <= mm_cs & ~mm_write;
        pd[0] <= mem_f(mm_address);
        for (int k = 1; k < RL; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
    end
    assign readdata = pv[RL-1] ? pd[RL-1] : 16'hDEAD;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arbitration rule: first requester at or after ptr, wrapping.
    function automatic int model_pick(input logic [3:0] req, input int ptr);
`ifdef PCM_ARB_CPU0_PRIO_EN
        if (req[0]) return 0;
        for (int k = 0; k < 4; k++) begin
            int c = (ptr + k) % 4;
            if (c != 0 && req[c]) return c;
        end
`else
        for (int k = 0; k < 4; k++) begin
            int c = (ptr + k) % 4;
            if (req[c]) return c;
        end
`endif
        return 0;
    endfunction

    task automatic init_pulse();
        a_req = '0;
        init  = 1'b1;
        tick();
        init  = 1'b0;
    endtask

    // Single isolated access from an idle arbiter.
    task automatic run_vec(input vec_t v);
        logic [3:0] oh = 4'b0001 << v.cpu;
        a_req[v.cpu]  = 1'b1;
        a_wr[v.cpu]   = v.wr;
        a_addr[v.cpu] = v.addr;
        a_data[v.cpu] = v.data;
        for (int c = 1; c <= v.lat + 1; c++) begin
            tick();
            if (c == 1) begin
                chk("vec_cs", mm_cs, 1);
                chk("vec_clken", mm_clken, 1);
                chk("vec_write", mm_write, v.wr);
                chk("vec_addr", mm_address, v.addr);
                chk("vec_be", mm_be, 2'b11);
                chk("vec_grant", grant, oh);
                if (v.wr) chk("vec_wdata", mm_wdata, v.data);
            end
            chk("vec_ready", cpu_ready, (c == v.lat) ? oh : 4'b0);
            if (c == v.lat) begin
                if (!v.wr) m_dout[v.cpu] = v.rd;
                chk("vec_dout", dout, m_dout);
                a_req[v.cpu] = 1'b0;
            end
            if (c == v.lat + 1) begin
                chk("vec_busy_end", busy, 0);
                chk("vec_cs_end", mm_cs, 0);
            end
        end
    endtask

    // Random requesters checked against a per-transaction timeline:
    // picked in cycle t -> issue at t+1 -> done at t+2 (write) or t+2+RL (read).
    task automatic run_model(input int n, input int pct, input bit rec);
        bit          act = 1'b0;
        bit          wr = 1'b0;
        bit          e_iss;
        int          win = 0, ptr = 0, iss_t = 0, done_t = 0, t = 0, drop_cpu;
        logic [19:0] ad = '0;
        logic [15:0] wd = '0;
        logic [3:0]  e_gnt, e_rdy;
        while (t < n || act) begin
            if (t > 0) tick();
            drop_cpu = -1;
            if (act && t > done_t) begin
                act         = 1'b0;
                ptr         = (win + 1) % 4;
                a_req[win]  = 1'b0;
                drop_cpu    = win;
            end
            e_iss = act && (t == iss_t);
            e_gnt = (act && t >= iss_t) ? 4'(1 << win) : 4'b0;
            e_rdy = (act && t == done_t) ? 4'(1 << win) : 4'b0;
            if (act && t == done_t && !wr) m_dout[win] = mem_f(ad);
            chk("rnd_busy", busy, act);
            chk("rnd_grant", grant, e_gnt);
            chk("rnd_ready", cpu_ready, e_rdy);
            chk("rnd_cs", mm_cs, e_iss);
            chk("rnd_clken", mm_clken, e_iss);
            chk("rnd_be", mm_be, e_iss ? 2'b11 : 2'b00);
            chk("rnd_write", mm_write, e_iss && wr);
            chk("rnd_dout", dout, m_dout);
            if (e_iss) begin
                chk("rnd_addr", mm_address, ad);
                if (wr) chk("rnd_wdata", mm_wdata, wd);
                if (rec) order.push_back(win);
            end
            if (t >= n) begin
                a_req = act ? (a_req & (4'b0001 << win)) : 4'b0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (!a_req[i] && i != drop_cpu && int'($urandom_range(99)) < pct) begin
                        a_req[i]  = 1'b1;
                        a_wr[i]   = 1'($urandom);
                        a_addr[i] = 20'($urandom);
                        a_data[i] = 16'($urandom);
                    end
                end
                if (!act && a_req != 4'b0) begin
                    win    = model_pick(a_req, ptr);
                    wr     = a_wr[win];
                    ad     = a_addr[win];
                    wd     = a_data[win];
                    iss_t  = t + 1;
                    done_t = wr ? t + 2 : t + 2 + RL;
                    act    = 1'b1;
                end
            end
            t++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        vec_t v;

        vecs[0] = '{2'd0, 1'b0, 20'h00606, 16'h0000, 4, 16'h0909};
        vecs[1] = '{2'd2, 1'b1, 20'h00010, 16'hBEEF, 2, 16'h0000};
        vecs[2] = '{2'd1, 1'b0, 20'h12344, 16'h0000, 4, 16'h34E6};
        vecs[3] = '{2'd3, 1'b0, 20'h00002, 16'h0000, 4, 16'h0003};
        vecs[4] = '{2'd1, 1'b1, 20'hFFFFF, 16'h0000, 2, 16'h0000};
        vecs[5] = '{2'd3, 1'b1, 20'h80001, 16'hFFFF, 2, 16'h0000};
        vecs[6] = '{2'd2, 1'b0, 20'hFFFFF, 16'h0000, 4, 16'h7FFE};

        reset  = 1'b1;
        init   = 1'b0;
        a_req  = '0;
        a_wr   = '0;
        a_addr = '0;
        a_data = '0;
        m_dout = '0;

        // Reset state
        #3 reset = 1'b0;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_ready", cpu_ready, 0);
        chk("rst_dout", dout, 0);
        chk("rst_cs", mm_cs, 0);
        chk("rst_clken", mm_clken, 0);
        chk("rst_write", mm_write, 0);
        chk("rst_be", mm_be, 0);
        chk("rst_addr", mm_address, 0);
        chk("rst_wdata", mm_wdata, 0);
        reset = 1'b1;
        repeat (4) tick();
        chk("rel_busy", busy, 0);

        // Directed single accesses
        foreach (vecs[i]) run_vec(vecs[i]);

        // init during a CPU1 read wait: abandoned, no ready, ptr cleared
        v = '{2'd0, 1'b1, 20'h00100, 16'h1234, 2, 16'h0000};
        run_vec(v);
        a_req[1]  = 1'b1;
        a_wr[1]   = 1'b0;
        a_addr[1] = 20'h00ABC;
        tick();
        chk("init_iss_cs", mm_cs, 1);
        chk("init_iss_grant", grant, 4'b0010);
        tick();
        chk("init_wait_busy", busy, 1);
        init  = 1'b1;
        a_req = '0;
        tick();
        init = 1'b0;
        chk("init_busy", busy, 0);
        chk("init_grant", grant, 0);
        chk("init_ready", cpu_ready, 0);
        chk("init_cs", mm_cs, 0);
        chk("init_dout", dout, m_dout);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("init_no_ready", cpu_ready, 0);
            chk("init_dout_hold", dout, m_dout);
        end
        a_req  = 4'b0011;
        a_wr   = 4'b0011;
        tick();
        chk("init_ptr_zero", grant, 4'b0001);
        init  = 1'b1;
        a_req = '0;
        tick();
        init = 1'b0;

        // All four requesters continuously active
        init_pulse();
        order.delete();
        run_model(40, 100, 1'b1);
        chk("cont_len", order.size() >= 5, 1);
`ifndef PCM_ARB_CPU0_PRIO_EN
        if (order.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("cont_order", order[i], exp_ord[i]);
        end
`endif

        // Randomized traffic
        init_pulse();
        run_model(1500, 35, 1'b0);

        // Reset during ISSUE: outputs drop immediately, no ready afterwards
        a_req[2]  = 1'b1;
        a_wr[2]   = 1'b1;
        a_addr[2] = 20'h00010;
        a_data[2] = 16'hBEEF;
        tick();
        chk("rstm_cs", mm_cs, 1);
        #2 reset = 1'b0;
        #1;
        chk("rstm_busy", busy, 0);
        chk("rstm_grant", grant, 0);
        chk("rstm_ready", cpu_ready, 0);
        chk("rstm_dout", dout, 0);
        chk("rstm_cs0", mm_cs, 0);
        chk("rstm_clken", mm_clken, 0);
        chk("rstm_write", mm_write, 0);
        chk("rstm_wdata", mm_wdata, 0);
        chk("rstm_addr", mm_address, 0);
        chk("rstm_be", mm_be, 0);
        a_req = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rstm_hold_ready", cpu_ready, 0);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("rstm_rel_busy", busy, 0);
            chk("rstm_rel_ready", cpu_ready, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
